// File: rtl/up_int_ctrl_if.sv
// Bus between the microprocessor controller and up_int_ctrl: latched address,
// write data, one-cycle read/write strobes and combinational read data.
interface up_int_ctrl_if;
  // Strobe protocol: ale latches bus_addr on its clk edge. A following mem_we or
  // mem_re pulse of exactly one cycle is one access. There is no stall; the slave
  // always accepts. bus_rdata is valid only during the mem_re cycle.
  logic       ale;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] bus_rdata;

  modport master (
    output ale, bus_addr, bus_wdata, mem_we, mem_re,
    input  bus_rdata
  );

  modport slave (
    input  ale, bus_addr, bus_wdata, mem_we, mem_re,
    output bus_rdata
  );
endinterface

// File: rtl/up_int_ctrl.sv
// Interrupt aggregator: edge-latched pending, mask, fixed priority, vector claim/EOI.
// UP_INT_CTRL_SYNC_EN adds a 2-flop source synchronizer. `int` is an SV keyword, so the request port is int_req.
module up_int_ctrl #(
  parameter int          NSRC = 8,
  parameter logic [7:0]  BASE = 8'hF0
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [NSRC-1:0] src,
  up_int_ctrl_if.slave    bus,
  output logic            int_req,
  output logic            state_dbg
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NSRC) - 9'd1);

  typedef enum logic {S_IDLE = 1'b0, S_SVC = 1'b1} state_t;

  state_t     state, state_n;
  logic [7:0] src_s, src_prev, rise;
  logic [7:0] addr_q;
  logic       hit;
  logic [1:0] off;
  logic       wr_acc, rd_acc, vec_rd, eoi;
  logic [7:0] pend, pend_n, mask, pm;
  logic       pm_any;
  logic [2:0] win_idx, svc_idx;
  logic       claim, insvc;

`ifdef UP_INT_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end
  assign src_s = 8'(sync2);
`else
  assign src_s = 8'(src);
`endif

  assign rise = src_s & ~src_prev & SRC_MASK;

  assign hit    = (addr_q[7:2] == BASE[7:2]);
  assign off    = addr_q[1:0];
  assign wr_acc = bus.mem_we & hit;
  // A simultaneous write wins; the read then has no side effect.
  assign rd_acc = bus.mem_re & hit & ~bus.mem_we;
  assign vec_rd = rd_acc & (off == 2'd2);
  assign eoi    = wr_acc & (off == 2'd3);

  assign pm     = pend & mask;
  assign pm_any = |pm;

  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pm[i]) win_idx = 3'(i);
    end
  end

  // Service FSM: state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Service FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (vec_rd && pm_any) state_n = S_SVC;
      S_SVC:  if (eoi)              state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Service FSM: outputs
  always_comb begin
    claim = 1'b0;
    insvc = 1'b0;
    case (state)
      S_IDLE: claim = vec_rd & pm_any;
      S_SVC:  insvc = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = insvc;

  // Rising edges are applied last so a same-cycle clear never loses a new edge.
  always_comb begin
    pend_n = pend;
    if (wr_acc && off == 2'd0) pend_n = pend_n & ~bus.bus_wdata;
    if (claim) pend_n[win_idx] = 1'b0;
    pend_n = (pend_n | rise) & SRC_MASK;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      src_prev <= '0;
      addr_q   <= '0;
      pend     <= '0;
      mask     <= '0;
      svc_idx  <= '0;
      int_req  <= 1'b0;
    end else begin
      src_prev <= src_s;
      if (bus.ale) addr_q <= bus.bus_addr;
      pend <= pend_n;
      if (wr_acc && off == 2'd1) mask <= bus.bus_wdata & SRC_MASK;
      if (claim) svc_idx <= win_idx;
      int_req <= pm_any & ~insvc;
    end
  end

  always_comb begin
    bus.bus_rdata = 8'h00;
    if (bus.mem_re && hit) begin
      case (off)
        2'd0: bus.bus_rdata = pend;
        2'd1: bus.bus_rdata = mask;
        2'd2: begin
          if (insvc)       bus.bus_rdata = {2'b01, 3'b000, svc_idx};
          else if (pm_any) bus.bus_rdata = {1'b1, 4'b0000, win_idx};
        end
        default: bus.bus_rdata = {7'b0, insvc};
      endcase
    end
  end

endmodule

// File: tb/tb_up_int_ctrl.sv
// Self-checking bench for up_int_ctrl: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_up_int_ctrl;

  localparam logic [7:0] BASE = 8'hF0;
`ifdef UP_INT_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       nRst;
  logic [7:0] src;
  logic       int_req;
  logic       state_dbg;

  up_int_ctrl_if bus ();

  up_int_ctrl #(.NSRC(8), .BASE(BASE)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .src       (src),
    .bus       (bus),
    .int_req   (int_req),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] m_pend, m_mask, cur_src;
  logic       m_insvc;
  logic [2:0] m_svc;

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_insvc = 1'b0; m_svc = 3'd0;
  endtask

  function automatic logic exp_int();
    return ((m_pend & m_mask) != 8'h00) && !m_insvc;
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] o);
    logic [7:0] pm;
    pm = m_pend & m_mask;
    case (o)
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: begin
        if (m_insvc) return 8'h40 | {5'b0, m_svc};
        for (int i = 0; i < 8; i++) if (pm[i]) return 8'h80 | 8'(i);
        return 8'h00;
      end
      default: return {7'b0, m_insvc};
    endcase
  endfunction

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input logic [7:0] v);
    @(negedge clk);
    m_pend  = m_pend | (v & ~cur_src);
    src     = v;
    cur_src = v;
  endtask

  task automatic pulse(input logic [7:0] v);
    set_src(v);
    idle(1);
    set_src(8'h00);
    idle(LAT + 2);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ale = 1'b1; bus.bus_addr = a;
    @(negedge clk);
    bus.ale = 1'b0; bus.mem_we = 1'b1; bus.bus_wdata = d;
    @(negedge clk);
    bus.mem_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.ale = 1'b1; bus.bus_addr = a;
    @(negedge clk);
    bus.ale = 1'b0; bus.mem_re = 1'b1;
    #1 d = bus.bus_rdata;
    @(negedge clk);
    bus.mem_re = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] o, input logic [7:0] d);
    bus_write(BASE + 8'(o), d);
    case (o)
      2'd0: m_pend = m_pend & ~d;
      2'd1: m_mask = d;
      2'd3: m_insvc = 1'b0;
      default: ;
    endcase
  endtask

  task automatic reg_read(input logic [1:0] o, output logic [7:0] d);
    logic [7:0] v;
    v = exp_read(2'd2);
    bus_read(BASE + 8'(o), d);
    if (o == 2'd2 && v[7]) begin
      m_pend[v[2:0]] = 1'b0;
      m_insvc = 1'b1;
      m_svc = v[2:0];
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    nRst = 1'b0; src = 8'h00; cur_src = 8'h00;
    bus.ale = 1'b0; bus.bus_addr = 8'h00; bus.bus_wdata = 8'h00;
    bus.mem_we = 1'b0; bus.mem_re = 1'b0;
    model_reset();
    idle(2);
    bus.mem_re = 1'b1;
    #1 got = bus.bus_rdata;
    bus.mem_re = 1'b0;
    tests_run++;
    if (int_req !== 1'b0 || state_dbg !== 1'b0 || got !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset: int=%b state=%b rdata=%h, required 0 0 00", int_req, state_dbg, got);
    end
    @(negedge clk) nRst = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_claim();
    logic [7:0] got;
    reg_write(2'd1, 8'h01);
    pulse(8'h01);
    reg_read(2'd0, got);
    tests_run++;
    if (got !== 8'h01 || int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_pend: pend=%h int=%b, required 01 1", got, int_req);
    end
    reg_read(2'd2, got);
    idle(1);
    tests_run++;
    if (got !== 8'h80 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_vector: vec=%h int=%b, required 80 0", got, int_req);
    end
    reg_read(2'd0, got);
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL basic_pend_cleared: pend=%h, required 00", got);
    end
    reg_write(2'd3, 8'h00);
    idle(2);
    tests_run++;
    if (int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_eoi: int=%b, required 0", int_req);
    end
  endtask

  task automatic test_priority();
    logic [7:0] got;
    reg_write(2'd1, 8'hFF);
    pulse(8'h24);
    reg_read(2'd2, got);
    tests_run++;
    if (got !== 8'h82) begin
      tests_failed++;
      $display("FAIL prio_first: vec=%h, required 82", got);
    end
    reg_read(2'd2, got);
    tests_run++;
    if (got !== 8'h42) begin
      tests_failed++;
      $display("FAIL prio_insvc: vec=%h, required 42", got);
    end
    reg_read(2'd0, got);
    tests_run++;
    if (got !== 8'h20) begin
      tests_failed++;
      $display("FAIL prio_pend: pend=%h, required 20", got);
    end
    reg_write(2'd3, 8'h00);
    idle(2);
    tests_run++;
    if (int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL prio_eoi_reraise: int=%b, required 1", int_req);
    end
    reg_read(2'd2, got);
    tests_run++;
    if (got !== 8'h85) begin
      tests_failed++;
      $display("FAIL prio_second: vec=%h, required 85", got);
    end
    reg_write(2'd3, 8'h00);
    idle(2);
  endtask

  task automatic test_mask();
    logic [7:0] got;
    reg_write(2'd1, 8'h00);
    pulse(8'h08);
    reg_read(2'd0, got);
    tests_run++;
    if (got !== 8'h08 || int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_latch: pend=%h int=%b, required 08 0", got, int_req);
    end
    reg_write(2'd1, 8'h08);
    tests_run++;
    if (int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_write_early: int=%b, required 0", int_req);
    end
    idle(1);
    tests_run++;
    if (int_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_enable: int=%b, required 1", int_req);
    end
    reg_write(2'd0, 8'h08);
    idle(1);
    tests_run++;
    if (int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask_w1c: int=%b, required 0", int_req);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got;
    pulse(8'h02);
    // Line the rise of src[1] (after synchronizer latency) up with the W1C edge
    @(negedge clk);
    if (LAT == 2) src = 8'h02;
    @(negedge clk);
    bus.ale = 1'b1; bus.bus_addr = BASE;
    @(negedge clk);
    bus.ale = 1'b0; bus.mem_we = 1'b1; bus.bus_wdata = 8'h02;
    if (LAT == 0) src = 8'h02;
    @(negedge clk);
    bus.mem_we = 1'b0;
    cur_src = 8'h02;
    m_pend = m_pend | 8'h02;
    set_src(8'h00);
    idle(LAT + 2);
    reg_read(2'd0, got);
    tests_run++;
    if (got !== m_pend || got[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_set_wins: pend=%h, required %h", got, m_pend);
    end
  endtask

  task automatic test_miss();
    logic [7:0] got;
    pulse(8'h10);
    for (int a = 4; a < 8; a++) bus_write(BASE + 8'(a), 8'hFF);
    bus_write(8'h10, 8'hFF);
    bus_read(BASE + 8'd4, got);
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL miss_read: rdata=%h, required 00", got);
    end
    for (int o = 0; o < 4; o++) begin
      logic [7:0] e;
      e = exp_read(2'(o));
      if (o == 2) continue;
      reg_read(2'(o), got);
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL miss_unchanged_%0d: rdata=%h, required %h", o, got, e);
      end
    end
  endtask

  task automatic test_latency();
    int k;
    reg_write(2'd0, 8'hFF);
    reg_write(2'd3, 8'h00);
    reg_write(2'd1, 8'h01);
    idle(2);
    tests_run++;
    if (int_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_pre: int=%b, required 0", int_req);
    end
    @(negedge clk);
    src = 8'h01; cur_src = 8'h01; m_pend = m_pend | 8'h01;
    k = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (int_req === 1'b1) begin
        k = e;
        break;
      end
    end
    tests_run++;
    if (k != 2 + LAT) begin
      tests_failed++;
      $display("FAIL latency_edges: int rose after %0d edges (0 = timeout), required %0d", k, 2 + LAT);
    end
    set_src(8'h00);
    idle(LAT + 2);
  endtask

  task automatic test_random();
    logic [7:0] got, e, v;
    logic [1:0] o;
    for (int it = 0; it < 60; it++) begin
      v = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0: pulse(v);
        1: reg_write(2'd1, v);
        2: reg_write(2'd0, v);
        3: begin
          e = exp_read(2'd2);
          reg_read(2'd2, got);
          tests_run++;
          if (got !== e) begin
            tests_failed++;
            $display("FAIL rand_vector it%0d: vec=%h, required %h", it, got, e);
          end
        end
        4: reg_write(2'd3, v);
        default: begin
          o = 2'($urandom_range(0, 3));
          e = exp_read(o);
          reg_read(o, got);
          tests_run++;
          if (got !== e) begin
            tests_failed++;
            $display("FAIL rand_read it%0d off%0d: rdata=%h, required %h", it, o, got, e);
          end
        end
      endcase
      idle(2);
      tests_run++;
      if (int_req !== exp_int()) begin
        tests_failed++;
        $display("FAIL rand_int it%0d: int=%b, required %b", it, int_req, exp_int());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    for (int pass = 0; pass < 2; pass++) begin
      reg_write(2'd1, 8'hFF);
      pulse(8'h11);
      if (pass == 1) reg_read(2'd2, got);
      idle(2);
      @(negedge clk);
      #2 nRst = 1'b0;
      bus.mem_re = 1'b1;
      #1 got = bus.bus_rdata;
      tests_run++;
      if (int_req !== 1'b0 || state_dbg !== 1'b0 || got !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_mid_%0d: int=%b state=%b rdata=%h, required 0 0 00", pass, int_req, state_dbg, got);
      end
      bus.mem_re = 1'b0;
      model_reset();
      @(negedge clk) nRst = 1'b1;
      for (int o = 0; o < 4; o++) begin
        reg_read(2'(o), got);
        tests_run++;
        if (got !== 8'h00) begin
          tests_failed++;
          $display("FAIL reset_mid_reg%0d_%0d: rdata=%h, required 00", o, pass, got);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_claim();
    test_priority();
    test_mask();
    test_simultaneous();
    test_miss();
    test_latency();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
